mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multiply/divide unit controller for the 5-stage MIPS pipeline, attached to the execute stage. It owns the architectural HI/LO registers. It commits the single-cycle results of mult/multu (products are precomputed in decode), mthi and mtlo. It sequences a 32-iteration restoring divider for div/divu and holds the execute stage via a ready handshake until the quotient and remainder are committed.

## Interface
Parameters:
- XLEN, 32, operand/result width; DIV_ITERS derives from it (= XLEN).

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- op_valid  in  1  execute stage holds a valid MDU instruction this cycle
- op_div  in  1  signed divide (rs / rt)
- op_divu  in  1  unsigned divide
- op_mul  in  1  mult or multu; commit mul_hi/mul_lo
- op_mthi  in  1  HI <= src1
- op_mtlo  in  1  LO <= src1
- src1  in  XLEN  rs value (dividend / mt source)
- src2  in  XLEN  rt value (divisor)
- mul_hi  in  XLEN  precomputed product upper half
- mul_lo  in  XLEN  precomputed product lower half
- op_accept  in  1  execute stage leaves this cycle (its ready_go & downstream allowin)
- op_ready  out  1  MDU side of execute ready_go
- busy  out  1  divider FSM not in IDLE
- hi_rdata  out  XLEN  current HI register
- lo_rdata  out  XLEN  current LO register

## Operation
- Op selects are mutually exclusive and qualified by op_valid. When none is set, op_ready=1 and there are no writes.
- mul/mthi/mtlo commit on the edge where op_valid & op_accept:
  - mul writes HI=mul_hi and LO=mul_lo.
  - mthi writes HI only.
  - mtlo writes LO only.
  - op_ready=1 in the same cycle.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - op_valid & (op_div|op_divu) drives op_ready=0.
  - On the next edge the controller latches the operand magnitudes (absolute values when signed, raw when unsigned), q_neg=sign1^sign2 (signed only), r_neg=sign1 (signed only), clears the remainder and count, and moves to RUN.
- RUN: one restoring step per cycle.
  - Shift {rem, quo} left 1.
  - Trial-subtract the divisor magnitude using XLEN+1 bits.
  - If the result is non-negative, keep it and set the quotient lsb.
  - count increments each cycle. After step DIV_ITERS the FSM moves to DONE.
  - On that same edge HI/LO are written:
    - LO = q_neg ? -quo : quo
    - HI = r_neg ? -rem : rem
  - Arithmetic is mod 2^XLEN.
- DONE:
  - op_ready=1.
  - Stays in DONE with no restart and no rewrite until op_accept, then returns to IDLE.
- Boundary results:
  - divu x/0 gives LO=all ones, HI=x.
  - div x/0 gives the magnitude result with sign fixup; no trap.
  - div 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide operands are latched at issue, so later changes to src1/src2 during RUN are ignored.
- busy = (state != IDLE).
- hi_rdata/lo_rdata are the registers directly, with no bypass. A write becomes visible the cycle after its commit edge.

## Timing
- Reset (async assert) gives state=IDLE, HI=0, LO=0, count=0, busy=0. op_ready is then combinational (1 unless a divide is presented).
- Reset asserted during RUN or DONE aborts the divide; HI and LO read 0 afterwards.
- Divide latency, with cycle 0 as the issue cycle in IDLE:
  - RUN occupies cycles 1..32.
  - DONE starts at cycle 33 with op_ready=1 and the HI/LO results already visible.
  - The minimum occupancy of execute is 34 cycles.
- op_accept is only sampled in IDLE (single-cycle ops) and DONE. It is ignored in RUN.
- Back-to-back operation: a divide may issue in the IDLE cycle right after DONE→IDLE. A mul immediately following a divide commits normally.

## Structure
- Shared package mdu_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - DIV_ITERS
  - the op-select bit order for a packed op vector.
- Sub-module div_iter_core contains the per-step shift/trial-subtract datapath: combinational inputs {rem, quo, divisor}, outputs {rem_next, quo_next}.
- The FSM, count, HI/LO registers and sign fixup stay in mdu_ctrl.

## Test plan
- divu 100/7 issued at cycle 0 → op_ready=0 for cycles 0..32. At cycle 33 op_ready=1, LO=14, HI=2.
- div 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- divu 5/0 → LO=0xFFFFFFFF, HI=5. div 0/3 → LO=0, HI=0.
- op_accept held low for 3 cycles in DONE → state stays DONE, op_ready=1, HI/LO unchanged, no new RUN. op_accept=1 → IDLE next cycle.
- mul with mul_hi=0x12345678 and mul_lo=0x9ABCDEF0 accepted → both registers update next cycle.
  - mthi 0xAA → HI=0xAA, LO unchanged.
  - mul with op_accept=0 → no write.
- Reset asserted at RUN step 10 → busy=0 and HI=LO=0 immediately. A following divu 9/3 completes normally with LO=3, HI=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU controller: FSM encoding, divide step count
// and the bit order of the packed op-select vector.
package mdu_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int DIV_ITERS = XLEN_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  localparam int OP_DIV  = 0;
  localparam int OP_DIVU = 1;
  localparam int OP_MUL  = 2;
  localparam int OP_MTHI = 3;
  localparam int OP_MTLO = 4;
  localparam int OP_W    = 5;

  typedef logic [OP_W-1:0] op_vec_t;
endpackage

// File: rtl/div_iter_core.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the
// divisor and keep the difference when it does not go negative.
module div_iter_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    trial  = rem_sh - {1'b0, divisor};
    // rem < divisor always holds, so the msb of trial is a clean sign bit
    if (!trial[XLEN]) begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/mdu_ctrl.sv
// Execute-stage MDU controller: owns HI/LO, commits mul/mthi/mtlo in one
// cycle and sequences a restoring divider, stalling execute via op_ready.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic            op_div,
  input  logic            op_divu,
  input  logic            op_mul,
  input  logic            op_mthi,
  input  logic            op_mtlo,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] mul_hi,
  input  logic [XLEN-1:0] mul_lo,
  input  logic            op_accept,
  output logic            op_ready,
  output logic            busy,
  output logic [XLEN-1:0] hi_rdata,
  output logic [XLEN-1:0] lo_rdata
);
  localparam int NITER = XLEN;
  localparam int CW    = $clog2(NITER + 1);
  localparam logic [CW-1:0] LAST = CW'(NITER - 1);

  mdu_state_e      state_q, state_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]   count_q, count_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  op_vec_t         op_v;
  logic            is_div, commit, s1, s2;
  logic [XLEN-1:0] rem_nx, quo_nx;

  div_iter_core #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_comb begin
    op_v = '0;
    if (op_valid) begin
      op_v[OP_DIV]  = op_div;
      op_v[OP_DIVU] = op_divu;
      op_v[OP_MUL]  = op_mul;
      op_v[OP_MTHI] = op_mthi;
      op_v[OP_MTLO] = op_mtlo;
    end
    is_div = op_v[OP_DIV] | op_v[OP_DIVU];
    commit = op_valid & op_accept & ~is_div;
    s1     = op_v[OP_DIV] & src1[XLEN-1];
    s2     = op_v[OP_DIV] & src2[XLEN-1];

    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    count_d  = count_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    op_ready = 1'b1;

    case (state_q)
      IDLE: begin
        op_ready = ~is_div;
        if (commit) begin
          if (op_v[OP_MUL]) begin
            hi_d = mul_hi;
            lo_d = mul_lo;
          end
          if (op_v[OP_MTHI]) hi_d = src1;
          if (op_v[OP_MTLO]) lo_d = src1;
        end
        if (is_div) begin
          quo_d   = s1 ? -src1 : src1;
          dvs_d   = s2 ? -src2 : src2;
          rem_d   = '0;
          count_d = '0;
          q_neg_d = s1 ^ s2;
          r_neg_d = s1;
          state_d = RUN;
        end
      end
      RUN: begin
        op_ready = 1'b0;
        rem_d    = rem_nx;
        quo_d    = quo_nx;
        count_d  = count_q + CW'(1);
        // final step: results land in HI/LO on the same edge that enters DONE
        if (count_q == LAST) begin
          state_d = DONE;
          lo_d    = q_neg_q ? -quo_nx : quo_nx;
          hi_d    = r_neg_q ? -rem_nx : rem_nx;
        end
      end
      DONE: begin
        op_ready = 1'b1;
        if (op_accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      count_q <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      count_q <= count_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign hi_rdata = hi_q;
  assign lo_rdata = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: divide latency/results, DONE hold, single-cycle
// commits and reset abort, against hand-computed values.
module tb_mdu_ctrl;
  logic        clk, reset;
  logic        op_valid, op_div, op_divu, op_mul, op_mthi, op_mtlo, op_accept;
  logic [31:0] src1, src2, mul_hi, mul_lo;
  logic        op_ready, busy;
  logic [31:0] hi_rdata, lo_rdata;

  int n_vec = 0;
  int n_bad = 0;

  mdu_ctrl #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_div(op_div),
    .op_divu(op_divu), .op_mul(op_mul), .op_mthi(op_mthi), .op_mtlo(op_mtlo),
    .src1(src1), .src2(src2), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .op_accept(op_accept), .op_ready(op_ready), .busy(busy),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_ops();
    op_valid = 0; op_div = 0; op_divu = 0; op_mul = 0; op_mthi = 0; op_mtlo = 0;
    op_accept = 0;
  endtask

  // issue at cycle 0, expect stall through cycle 32, results at cycle 33
  task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int hold);
    int hi_cnt;
    @(negedge clk);
    idle_ops();
    op_valid = 1; op_div = sgn; op_divu = ~sgn; src1 = a; src2 = b;
    #1 chk({tag, ".rdy_issue"}, {31'd0, op_ready}, 0);
    hi_cnt = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      src1 = ~a; src2 = b + 32'd1;
      #1 if (op_ready || !busy) hi_cnt++;
    end
    chk({tag, ".run_stall"}, hi_cnt, 0);
    @(negedge clk);
    #1;
    chk({tag, ".rdy_done"}, {31'd0, op_ready}, 1);
    chk({tag, ".lo"}, lo_rdata, exp_lo);
    chk({tag, ".hi"}, hi_rdata, exp_hi);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk({tag, ".hold_rdy"}, {31'd0, op_ready}, 1);
      chk({tag, ".hold_busy"}, {31'd0, busy}, 1);
      chk({tag, ".hold_lo"}, lo_rdata, exp_lo);
      chk({tag, ".hold_hi"}, hi_rdata, exp_hi);
    end
    op_accept = 1;
    @(negedge clk);
    idle_ops();
    #1;
    chk({tag, ".idle_busy"}, {31'd0, busy}, 0);
    chk({tag, ".idle_lo"}, lo_rdata, exp_lo);
    chk({tag, ".idle_hi"}, hi_rdata, exp_hi);
  endtask

  task automatic single(input string tag, input bit mul, input bit mthi, input bit mtlo,
                        input bit acc, input logic [31:0] s, input logic [31:0] mh,
                        input logic [31:0] ml, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    @(negedge clk);
    idle_ops();
    op_valid = 1; op_mul = mul; op_mthi = mthi; op_mtlo = mtlo; op_accept = acc;
    src1 = s; mul_hi = mh; mul_lo = ml;
    #1 chk({tag, ".rdy"}, {31'd0, op_ready}, 1);
    @(negedge clk);
    idle_ops();
    #1;
    chk({tag, ".hi"}, hi_rdata, exp_hi);
    chk({tag, ".lo"}, lo_rdata, exp_lo);
  endtask

  initial begin
    idle_ops();
    src1 = 0; src2 = 0; mul_hi = 0; mul_lo = 0;
    reset = 1;
    #12;
    chk("rst.hi", hi_rdata, 0);
    chk("rst.lo", lo_rdata, 0);
    chk("rst.busy", {31'd0, busy}, 0);
    chk("rst.rdy", {31'd0, op_ready}, 1);
    @(negedge clk);
    reset = 0;

    run_div("divu100_7", 0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    run_div("div_m7_2", 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 3);
    run_div("div_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
    run_div("divu5_0", 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0);
    run_div("div0_3", 1, 32'd0, 32'd3, 32'd0, 32'd0, 0);
    run_div("div7_m2", 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);

    // mul right after a divide, then mthi/mtlo and an unaccepted mul
    single("mul", 1, 0, 0, 1, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0,
           32'h1234_5678, 32'h9ABC_DEF0);
    single("mthi", 0, 1, 0, 1, 32'h0000_00AA, 32'd0, 32'd0,
           32'h0000_00AA, 32'h9ABC_DEF0);
    single("mtlo", 0, 0, 1, 1, 32'h0000_0055, 32'd0, 32'd0,
           32'h0000_00AA, 32'h0000_0055);
    single("mul_noacc", 1, 0, 0, 0, 32'd0, 32'hDEAD_BEEF, 32'hCAFE_F00D,
           32'h0000_00AA, 32'h0000_0055);

    // abort a divide mid-run with async reset
    @(negedge clk);
    idle_ops();
    op_valid = 1; op_divu = 1; src1 = 32'd100; src2 = 32'd7;
    repeat (10) @(negedge clk);
    #1 chk("abort.busy_pre", {31'd0, busy}, 1);
    reset = 1;
    #1;
    chk("abort.busy", {31'd0, busy}, 0);
    chk("abort.hi", hi_rdata, 0);
    chk("abort.lo", lo_rdata, 0);
    @(negedge clk);
    idle_ops();
    reset = 0;
    run_div("divu9_3", 0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
